mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 mux datapath (mux4 select path) among four requesters.
- Registers a one-hot grant and drives the mux4 2-bit `control` select so the granted source's data reaches the shared output.
- Bounds each tenure with a hold limit so no requester can starve the others.
- Sits between the requesting units and the shared mux4 instance.

---
 rtl/mux4_rr_arbiter.sv | 113 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the shared mux4 select with a bounded hold time
// Optional: define MUX4_ARB_PRIORITY0_EN to give requester 0 absolute priority at each grant decision.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] control,
  output logic       busy,
  output logic       switch_pulse
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       last_ptr;

  logic [1:0] search_ptr;
  logic [1:0] winner;
  logic       release_now;
  logic       any_req;
  logic       update_ptr;

  // First requester found scanning ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    any_req     = |req;
    release_now = !req[control] || (hold_cnt == HOLD_LAST);
`ifdef MUX4_ARB_PRIORITY0_EN
    // Requester-0 tenures leave the rotation pointer untouched so 1..3 resume in order.
    update_ptr = (control != 2'd0);
    search_ptr = (state == GRANT && control != 2'd0) ? control : last_ptr;
    winner     = req[0] ? 2'd0 : rr_pick(search_ptr, req);
`else
    update_ptr = 1'b1;
    search_ptr = (state == GRANT) ? control : last_ptr;
    winner     = rr_pick(search_ptr, req);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= 4'b0000;
      control      <= 2'd0;
      busy         <= 1'b0;
      switch_pulse <= 1'b0;
      hold_cnt     <= '0;
      last_ptr     <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= GRANT;
            grant        <= 4'b0001 << winner;
            control      <= winner;
            busy         <= 1'b1;
            switch_pulse <= 1'b1;
            hold_cnt     <= '0;
          end else begin
            switch_pulse <= 1'b0;
          end
        end
        GRANT: begin
          if (!release_now) begin
            hold_cnt     <= hold_cnt + CNT_W'(1);
            switch_pulse <= 1'b0;
          end else begin
            if (update_ptr) last_ptr <= control;
            hold_cnt <= '0;
            if (any_req) begin
              // Hand over directly; the releasing holder may win again if it is alone.
              grant        <= 4'b0001 << winner;
              control      <= winner;
              switch_pulse <= 1'b1;
            end else begin
              state        <= IDLE;
              grant        <= 4'b0000;
              busy         <= 1'b0;
              switch_pulse <= 1'b0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          grant        <= 4'b0000;
          busy         <= 1'b0;
          switch_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter (MAX_HOLD=4 and MAX_HOLD=1 instances)
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] control_a, control_b;
  logic       busy_a, busy_b, sw_a, sw_b;
  logic [7:0] obs_a, obs_b;

  assign obs_a = {grant_a, control_a, busy_a, sw_a};
  assign obs_b = {grant_b, control_b, busy_b, sw_b};

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .req(req_a), .grant(grant_a),
    .control(control_a), .busy(busy_a), .switch_pulse(sw_a)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .req(req_b), .grant(grant_b),
    .control(control_b), .busy(busy_b), .switch_pulse(sw_b)
  );

  typedef struct {
    logic [7:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] mk(input logic [3:0] g, input logic [1:0] c, input logic b, input logic s);
    return {g, c, b, s};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    req_a = 4'b1111;
    req_b = 4'b1111;
    exp_q.push_back('{8'h00, "reset_a"});
    exp_q.push_back('{8'h00, "reset_b"});
    @(posedge clock); #1;
    e = exp_q.pop_front(); checks++;
    if (obs_a !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v); end
    e = exp_q.pop_front(); checks++;
    if (obs_b !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs_b, e.v); end
    req_a = 4'b0000;
    req_b = 4'b0000;
    reset = 1'b1;
    exp_q.push_back('{8'h00, "idle_no_req"});
    @(posedge clock); #1;
    e = exp_q.pop_front(); checks++;
    if (obs_a !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v); end
  endtask

  task automatic test_single();
    logic [3:0] rq[2];
    logic [7:0] ev[2];
    exp_t e;
    rq = '{4'b0100, 4'b0000};
    ev = '{mk(4'b0100, 2'd2, 1'b1, 1'b1), mk(4'b0000, 2'd2, 1'b0, 1'b0)};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req_a = rq[i];
      exp_q.push_back('{ev[i], "single"});
      @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs_a !== e.v) begin errors++; $display("FAIL %s step %0d: got %b expected %b", e.name, i, obs_a, e.v); end
    end
  endtask

  task automatic test_contention();
    int   w;
    exp_t e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
`ifdef MUX4_ARB_PRIORITY0_EN
      w = 0;
`else
      w = (i / 4) % 4;
`endif
      req_a = 4'b1111;
      exp_q.push_back('{mk(4'b0001 << w, 2'(w), 1'b1, (i % 4) == 0), "contention"});
      @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs_a !== e.v) begin errors++; $display("FAIL %s cycle %0d: got %b expected %b", e.name, i, obs_a, e.v); end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] rq[4];
    logic [7:0] ev[4];
    exp_t e;
    rq = '{4'b0010, 4'b1010, 4'b1000, 4'b0000};
    ev = '{mk(4'b0010, 2'd1, 1'b1, 1'b1), mk(4'b0010, 2'd1, 1'b1, 1'b0),
           mk(4'b1000, 2'd3, 1'b1, 1'b1), mk(4'b0000, 2'd3, 1'b0, 1'b0)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a = rq[i];
      exp_q.push_back('{ev[i], "early_release"});
      @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs_a !== e.v) begin errors++; $display("FAIL %s step %0d: got %b expected %b", e.name, i, obs_a, e.v); end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    req_a = 4'b0010;
    exp_q.push_back('{mk(4'b0010, 2'd1, 1'b1, 1'b1), "async_pre"});
    @(posedge clock); #1;
    e = exp_q.pop_front(); checks++;
    if (obs_a !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v); end
    #2;
    reset = 1'b0;
    exp_q.push_back('{8'h00, "async_mid"});
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs_a !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v); end
    req_a = 4'b0110;
    @(negedge clock);
    reset = 1'b1;
    exp_q.push_back('{mk(4'b0010, 2'd1, 1'b1, 1'b1), "async_restart"});
    @(posedge clock); #1;
    e = exp_q.pop_front(); checks++;
    if (obs_a !== e.v) begin errors++; $display("FAIL %s: got %b expected %b", e.name, obs_a, e.v); end
  endtask

  task automatic test_max_hold1();
    int   w;
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
`ifdef MUX4_ARB_PRIORITY0_EN
      w = 0;
`else
      w = (i % 2) * 2;
`endif
      req_b = 4'b0101;
      exp_q.push_back('{mk(4'b0001 << w, 2'(w), 1'b1, 1'b1), "hold1_0101"});
      @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e.v) begin errors++; $display("FAIL %s cycle %0d: got %b expected %b", e.name, i, obs_b, e.v); end
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
`ifdef MUX4_ARB_PRIORITY0_EN
      w = 0;
`else
      w = i % 4;
`endif
      req_b = 4'b1111;
      exp_q.push_back('{mk(4'b0001 << w, 2'(w), 1'b1, 1'b1), "hold1_1111"});
      @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs_b !== e.v) begin errors++; $display("FAIL %s cycle %0d: got %b expected %b", e.name, i, obs_b, e.v); end
    end
  endtask

  task automatic test_nonholder_drop();
    logic [3:0] rq[3];
    logic [7:0] ev[3];
    exp_t e;
    rq = '{4'b0101, 4'b0001, 4'b0001};
    ev = '{mk(4'b0001, 2'd0, 1'b1, 1'b1), mk(4'b0001, 2'd0, 1'b1, 1'b0), mk(4'b0001, 2'd0, 1'b1, 1'b0)};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_a = rq[i];
      exp_q.push_back('{ev[i], "nonholder_drop"});
      @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs_a !== e.v) begin errors++; $display("FAIL %s step %0d: got %b expected %b", e.name, i, obs_a, e.v); end
    end
  endtask

  task automatic test_limit_handover();
    logic [3:0] rq[6];
    logic [7:0] ev[6];
    exp_t e;
    rq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1101, 4'b1100};
`ifdef MUX4_ARB_PRIORITY0_EN
    ev = '{mk(4'b0100, 2'd2, 1'b1, 1'b1), mk(4'b0100, 2'd2, 1'b1, 1'b0),
           mk(4'b0100, 2'd2, 1'b1, 1'b0), mk(4'b0100, 2'd2, 1'b1, 1'b0),
           mk(4'b0001, 2'd0, 1'b1, 1'b1), mk(4'b1000, 2'd3, 1'b1, 1'b1)};
`else
    ev = '{mk(4'b0100, 2'd2, 1'b1, 1'b1), mk(4'b0100, 2'd2, 1'b1, 1'b0),
           mk(4'b0100, 2'd2, 1'b1, 1'b0), mk(4'b0100, 2'd2, 1'b1, 1'b0),
           mk(4'b1000, 2'd3, 1'b1, 1'b1), mk(4'b1000, 2'd3, 1'b1, 1'b0)};
`endif
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req_a = rq[i];
      exp_q.push_back('{ev[i], "limit_handover"});
      @(posedge clock); #1;
      e = exp_q.pop_front(); checks++;
      if (obs_a !== e.v) begin errors++; $display("FAIL %s step %0d: got %b expected %b", e.name, i, obs_a, e.v); end
    end
  endtask

  initial begin
    reset = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_async_reset();
    test_max_hold1();
    test_nonholder_drop();
    test_limit_handover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
